// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin arbiter sharing one data memory port between two
//                requesters, with registered read data and a one-cycle ack.
// Revision 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          ack0,
  output logic [DW-1:0] rd0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          ack1,
  output logic [DW-1:0] rd1,
  output logic          stall1,
  output logic          m_we,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_sel;
  logic   w_sel_nxt;
  logic   r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      rd0     <= '0;
      rd1     <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      // Acks are high exactly during RESP, for the port served in ACCESS.
      ack0    <= (r_state == ACCESS) && !r_sel;
      ack1    <= (r_state == ACCESS) && r_sel;
      if (r_state == ACCESS) begin
        r_last <= r_sel;
        if (!r_sel && !we0) rd0 <= m_rd;
        if (r_sel && !we1)  rd1 <= m_rd;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    m_we        = 1'b0;
    m_address   = '0;
    m_wd        = '0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = ACCESS;
          // On contention the port that was not served last wins.
          w_sel_nxt   = (req0 && req1) ? ~r_last : req1;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
        m_we        = r_sel ? we1   : we0;
        m_address   = r_sel ? addr1 : addr0;
        m_wd        = r_sel ? wd1   : wd0;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy   = (r_state != IDLE);
  assign stall0 = req0 & ~ack0;
  assign stall1 = req1 & ~ack1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed and randomized checks of dmem_arbiter against a
//                   transaction-level scheduling model.
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [2:0]    gap;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic          ack0, ack1, stall0, stall1, m_we, busy;
  logic [DW-1:0] rd0, rd1, m_wd, m_rd;
  logic [AW-1:0] m_address;

  // Environment data memory: combinational read, write on the rising edge.
  logic          mem_clr = 1'b1;
  logic [DW-1:0] mem [0:255];
  assign m_rd = mem[m_address[9:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (m_we) begin
      mem[m_address[9:2]] <= m_wd;
    end
  end

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0), .ack0(ack0), .rd0(rd0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .ack1(ack1), .rd1(rd1), .stall1(stall1),
    .m_we(m_we), .m_address(m_address), .m_wd(m_wd), .m_rd(m_rd), .busy(busy)
  );

  int            tests = 0;
  int            fails = 0;
  int            cyc, free_at, last_m, exp_ack_cyc, exp_port, access_cyc;
  txn_t          pend;
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] ref_mem [0:255];
  txn_t          q [2][$];
  txn_t          cur [2];
  bit            act [2];
  int            waitc [2];
  int            ack_cyc_log [$];
  int            ack_port_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cyc = -1; free_at = 0; last_m = 1;
    exp_ack_cyc = -100; access_cyc = -100; exp_port = 0; pend = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    ack_cyc_log.delete(); ack_port_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; waitc[p] = 0; q[p].delete();
    end
    #1;
    chk("rst_m_we", m_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ack0", ack0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: check registered outputs, advance requesters, schedule.
  task automatic step();
    bit   ea [2];
    txn_t prev [2];
    bit   prev_act [2];
    int   g;
    @(posedge clk);
    #1;
    cyc++;
    ea[0] = (cyc == exp_ack_cyc) && (exp_port == 0);
    ea[1] = (cyc == exp_ack_cyc) && (exp_port == 1);
    if (cyc == exp_ack_cyc) begin
      if (pend.we) ref_mem[pend.addr[9:2]] = pend.wd;
      else         exp_rd[exp_port] = ref_mem[pend.addr[9:2]];
      ack_cyc_log.push_back(cyc);
      ack_port_log.push_back(exp_port);
    end
    chk("ack0", ack0, ea[0]);
    chk("ack1", ack1, ea[1]);
    chk("busy", busy, (cyc >= free_at - 2) && (cyc < free_at));
    chk("rd0", rd0, exp_rd[0]);
    chk("rd1", rd1, exp_rd[1]);

    for (int p = 0; p < 2; p++) begin
      prev[p] = cur[p];
      prev_act[p] = act[p];
      if (act[p] && ea[p]) act[p] = 1'b0;
      if (!act[p] && q[p].size() > 0) begin
        if (waitc[p] >= int'(q[p][0].gap)) begin
          cur[p] = q[p].pop_front();
          act[p] = 1'b1;
          waitc[p] = 0;
        end else begin
          waitc[p]++;
        end
      end
      assert (!(prev_act[p] && act[p] && !ea[p] && cur[p] != prev[p])) else begin
        fails++;
        $error("FAIL protocol port%0d request changed before ack", p);
      end
    end
    req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; wd0 = cur[0].wd;
    req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; wd1 = cur[1].wd;

    // Arbiter is free: grant per round-robin, ack two cycles later.
    if (cyc >= free_at && (act[0] || act[1])) begin
      if (act[0] && act[1]) g = 1 - last_m;
      else                  g = act[1] ? 1 : 0;
      last_m = g; exp_port = g; pend = cur[g];
      access_cyc = cyc + 1; exp_ack_cyc = cyc + 2; free_at = cyc + 3;
    end
    #1;
    chk("stall0", stall0, act[0] && !ea[0]);
    chk("stall1", stall1, act[1] && !ea[1]);
    chk("m_we", m_we, (cyc == access_cyc) && pend.we);
    chk("m_address", m_address, (cyc == access_cyc) ? pend.addr : 32'h0);
    if (cyc == access_cyc && pend.we) chk("m_wd", m_wd, pend.wd);
    chk("ack_excl", ack0 && ack1, 0);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    bit still;
    n = 0;
    do begin
      step();
      n++;
      still = (q[0].size() > 0) || (q[1].size() > 0) || act[0] || act[1] || (cyc < free_at);
    end while (still && n < budget);
    chk("drain_timeout", still, 0);
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wd = wd; t.gap = 3'(gap);
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    cur[0] = '0; cur[1] = '0;
    model_clear();
    do_reset();
    mem_clr = 1'b0;

    // Port 0 alone: store then load.
    q[0].push_back(mk(1'b1, 32'h54, 32'hDEADBEEF, 0));
    q[0].push_back(mk(1'b0, 32'h54, 32'h0, 0));
    run_until_idle(50);
    chk("t1_rd0", rd0, 32'hDEADBEEF);
    chk("t1_nacks", ack_cyc_log.size(), 2);
    if (ack_cyc_log.size() == 2) begin
      chk("t1_ack_store_cyc", ack_cyc_log[0], 2);
      chk("t1_ack_load_cyc", ack_cyc_log[1], 5);
    end

    // Preload two words, then simultaneous loads from reset.
    q[0].push_back(mk(1'b1, 32'h10, 32'hA5A5_0010, 0));
    q[0].push_back(mk(1'b1, 32'h20, 32'h5A5A_0020, 0));
    run_until_idle(50);
    do_reset();
    q[0].push_back(mk(1'b0, 32'h10, 32'h0, 0));
    q[1].push_back(mk(1'b0, 32'h20, 32'h0, 0));
    run_until_idle(50);
    chk("t2_nacks", ack_cyc_log.size(), 2);
    if (ack_cyc_log.size() == 2) begin
      chk("t2_first_port", ack_port_log[0], 0);
      chk("t2_first_cyc", ack_cyc_log[0], 2);
      chk("t2_second_port", ack_port_log[1], 1);
      chk("t2_second_cyc", ack_cyc_log[1], 5);
    end
    chk("t2_rd0", rd0, 32'hA5A5_0010);
    chk("t2_rd1", rd1, 32'h5A5A_0020);

    // Both ports requesting back-to-back.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(mk(1'b0, 32'($urandom_range(0, 15)) * 4, 32'h0, 0));
      q[1].push_back(mk(1'b0, 32'($urandom_range(0, 15)) * 4, 32'h0, 0));
    end
    run_until_idle(100);
    chk("t3_nacks", ack_cyc_log.size(), 8);
    if (ack_cyc_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t3_order", ack_port_log[i], i % 2);
        if (i > 0) chk("t3_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 3);
      end
    end

    // Port 1 store, port 0 load of the same word one cycle later.
    do_reset();
    q[1].push_back(mk(1'b1, 32'h40, 32'h12345678, 0));
    q[0].push_back(mk(1'b0, 32'h40, 32'h0, 1));
    run_until_idle(50);
    chk("t4_nacks", ack_cyc_log.size(), 2);
    if (ack_cyc_log.size() == 2) chk("t4_first_port", ack_port_log[0], 1);
    chk("t4_rd0", rd0, 32'h12345678);

    // Reset during ACCESS of a store: write dropped, no ack.
    do_reset();
    q[0].push_back(mk(1'b1, 32'h80, 32'hCAFEF00D, 0));
    step();
    step();
    chk("t5_in_access", m_we, 1);
    do_reset();
    q[0].push_back(mk(1'b0, 32'h80, 32'h0, 0));
    run_until_idle(50);
    chk("t5_nacks", ack_cyc_log.size(), 1);
    chk("t5_rd0", rd0, 32'h0);

    // Idle bus, then a single port 1 request.
    do_reset();
    repeat (10) step();
    chk("t6_idle_acks", ack_cyc_log.size(), 0);
    q[1].push_back(mk(1'b0, 32'h40, 32'h0, 0));
    run_until_idle(50);
    chk("t6_nacks", ack_cyc_log.size(), 1);
    if (ack_cyc_log.size() == 1) chk("t6_ack_cyc", ack_cyc_log[0], 12);
    chk("t6_rd1", rd1, 32'h12345678);

    // Randomized mixed traffic.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      q[0].push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 4,
                        $urandom, $urandom_range(0, 3)));
      q[1].push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 4,
                        $urandom, $urandom_range(0, 3)));
    end
    run_until_idle(2000);
    chk("rand_nacks", ack_cyc_log.size(), 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
